// File: rtl/dbus_pkg.sv
// Shared definitions for the data-bus controller: access size codes, FSM states
// and the alignment rule applied to every core request.
package dbus_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } dbus_state_t;

  // Size code 2'b11 is illegal and is treated as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_WORD: bad = (addr_lo != 2'b00);
      SIZE_HALF: bad = addr_lo[0];
      SIZE_BYTE: bad = 1'b0;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dbus_lane_align.sv
// Byte-lane steering for stores (enables + replicated data) and lane
// extraction with sign/zero extension for loads. Purely combinational.
module dbus_lane_align
  import dbus_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_lane_data,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store side: byte enables and lane-replicated write data.
  always_comb begin
    st_be        = 4'b0000;
    st_lane_data = 32'h0000_0000;
    case (st_size)
      SIZE_WORD: begin
        st_be        = 4'b1111;
        st_lane_data = st_data;
      end
      SIZE_HALF: begin
        st_be        = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_lane_data = {2{st_data[15:0]}};
      end
      SIZE_BYTE: begin
        st_be        = 4'b0001 << st_addr_lo;
        st_lane_data = {4{st_data[7:0]}};
      end
      default: begin
        st_be        = 4'b0000;
        st_lane_data = 32'h0000_0000;
      end
    endcase
  end

  // Load side: select the addressed lane, then extend to 32 bits.
  always_comb begin
    byte_s  = 8'h00;
    half_s  = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    ld_data = 32'h0000_0000;
    case (ld_addr_lo)
      2'b00:   byte_s = ld_rdata[7:0];
      2'b01:   byte_s = ld_rdata[15:8];
      2'b10:   byte_s = ld_rdata[23:16];
      default: byte_s = ld_rdata[31:24];
    endcase
    case (ld_size)
      SIZE_WORD: ld_data = ld_rdata;
      SIZE_HALF: ld_data = {{16{half_s[15] & ~ld_unsigned}}, half_s};
      SIZE_BYTE: ld_data = {{24{byte_s[7] & ~ld_unsigned}}, byte_s};
      default:   ld_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dbus_ctrl.sv
// Data-bus controller: registers core load/store requests, drives the memory bus
// and stalls the core until ack. Define DBUS_TIMEOUT_EN to abort accesses lacking ack.
module dbus_ctrl
  import dbus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic        core_write,
  input  logic [1:0]  core_size,
  input  logic        core_unsigned,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_stall,
  output logic        core_done,
  output logic        core_err,
  output logic [31:0] core_rdata,
  output logic        mem_req,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack_n
);

  dbus_state_t state_r;
  logic        mem_req_r, mem_write_r, core_done_r, core_err_r, ld_unsigned_r;
  logic [31:0] mem_addr_r, mem_wdata_r, core_rdata_r;
  logic [3:0]  mem_be_r;
  logic [1:0]  ld_size_r, ld_addr_lo_r;
  logic [3:0]  st_be_s;
  logic [31:0] st_lane_data_s, ld_data_s;

`ifdef DBUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] busy_cnt_r;
`endif

  dbus_lane_align u_lane (
    .st_size      (core_size),
    .st_addr_lo   (core_addr[1:0]),
    .st_data      (core_wdata),
    .st_be        (st_be_s),
    .st_lane_data (st_lane_data_s),
    .ld_size      (ld_size_r),
    .ld_addr_lo   (ld_addr_lo_r),
    .ld_unsigned  (ld_unsigned_r),
    .ld_rdata     (mem_rdata),
    .ld_data      (ld_data_s)
  );

  // The core must see the stall in the same cycle it raises a request.
  assign core_stall = (state_r == ST_BUSY) | ((state_r == ST_IDLE) & core_req);
  assign core_done  = core_done_r;
  assign core_err   = core_err_r;
  assign core_rdata = core_rdata_r;
  assign mem_req    = mem_req_r;
  assign mem_write  = mem_write_r;
  assign mem_addr   = mem_addr_r;
  assign mem_be     = mem_be_r;
  assign mem_wdata  = mem_wdata_r;

  // Access FSM with registered bus and completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      mem_req_r     <= 1'b0;
      mem_write_r   <= 1'b0;
      mem_addr_r    <= 32'h0000_0000;
      mem_be_r      <= 4'b0000;
      mem_wdata_r   <= 32'h0000_0000;
      core_done_r   <= 1'b0;
      core_err_r    <= 1'b0;
      core_rdata_r  <= 32'h0000_0000;
      ld_size_r     <= 2'b00;
      ld_addr_lo_r  <= 2'b00;
      ld_unsigned_r <= 1'b0;
`ifdef DBUS_TIMEOUT_EN
      busy_cnt_r    <= '0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          core_done_r  <= 1'b0;
          core_err_r   <= 1'b0;
          core_rdata_r <= 32'h0000_0000;
          if (core_req && is_misaligned(core_size, core_addr[1:0])) begin
            state_r     <= ST_DONE;
            core_done_r <= 1'b1;
            core_err_r  <= 1'b1;
          end else if (core_req) begin
            state_r       <= ST_BUSY;
            mem_req_r     <= 1'b1;
            mem_write_r   <= core_write;
            mem_addr_r    <= {core_addr[31:2], 2'b00};
            mem_be_r      <= st_be_s;
            mem_wdata_r   <= core_write ? st_lane_data_s : 32'h0000_0000;
            ld_size_r     <= core_size;
            ld_addr_lo_r  <= core_addr[1:0];
            ld_unsigned_r <= core_unsigned;
`ifdef DBUS_TIMEOUT_EN
            busy_cnt_r    <= '0;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (!mem_ack_n) begin
            state_r      <= ST_DONE;
            core_done_r  <= 1'b1;
            core_rdata_r <= mem_write_r ? 32'h0000_0000 : ld_data_s;
            mem_req_r    <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_addr_r   <= 32'h0000_0000;
            mem_be_r     <= 4'b0000;
            mem_wdata_r  <= 32'h0000_0000;
          end
`ifdef DBUS_TIMEOUT_EN
          else if (busy_cnt_r == CNT_LAST) begin
            state_r     <= ST_DONE;
            core_done_r <= 1'b1;
            core_err_r  <= 1'b1;
            mem_req_r   <= 1'b0;
            mem_write_r <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_be_r    <= 4'b0000;
            mem_wdata_r <= 32'h0000_0000;
          end else begin
            busy_cnt_r <= busy_cnt_r + CNT_W'(1);
          end
`else
          else begin
            state_r <= ST_BUSY;
          end
`endif
        end
        ST_DONE: begin
          state_r      <= ST_IDLE;
          core_done_r  <= 1'b0;
          core_err_r   <= 1'b0;
          core_rdata_r <= 32'h0000_0000;
        end
        default: begin
          state_r     <= ST_IDLE;
          mem_req_r   <= 1'b0;
          core_done_r <= 1'b0;
          core_err_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_ctrl.sv
// Self-checking bench for dbus_ctrl: transaction-level timeline model checked every
// cycle, directed cases with literal expectations, then randomized traffic.
module tb_dbus_ctrl;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_write, core_unsigned;
  logic [1:0]  core_size;
  logic [31:0] core_addr, core_wdata;
  logic        core_stall, core_done, core_err;
  logic [31:0] core_rdata;
  logic        mem_req, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ack_n;

  dbus_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .core_req(core_req), .core_write(core_write),
    .core_size(core_size), .core_unsigned(core_unsigned), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_stall(core_stall), .core_done(core_done),
    .core_err(core_err), .core_rdata(core_rdata), .mem_req(mem_req),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack_n(mem_ack_n)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;
  logic        e_stall, e_done, e_err, e_req, e_write;
  logic [31:0] e_rdata, e_addr, e_wdata;
  logic [3:0]  e_be;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model's expectation for this cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("core_stall", {31'b0, core_stall}, {31'b0, e_stall});
      chk("core_done",  {31'b0, core_done},  {31'b0, e_done});
      chk("core_err",   {31'b0, core_err},   {31'b0, e_err});
      chk("core_rdata", core_rdata, e_rdata);
      chk("mem_req",    {31'b0, mem_req},    {31'b0, e_req});
      chk("mem_write",  {31'b0, mem_write},  {31'b0, e_write});
      chk("mem_addr",   mem_addr, e_addr);
      chk("mem_be",     {28'b0, mem_be},     {28'b0, e_be});
      chk("mem_wdata",  mem_wdata, e_wdata);
    end
  end

  task automatic exp_quiet(input logic stall);
    e_stall = stall; e_done = 1'b0; e_err = 1'b0; e_rdata = 32'h0;
    e_req = 1'b0; e_write = 1'b0; e_addr = 32'h0; e_be = 4'h0; e_wdata = 32'h0;
  endtask

  function automatic logic misal(input logic [1:0] sz, input int a);
    return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd0 && (a % 4) != 0);
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] sz, input int a);
    if (sz == 2'd0) return 4'hF;
    if (sz == 2'd1) return (a >= 2) ? 4'hC : 4'h3;
    return 4'(1 << a);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] wd);
    int unsigned v;
    v = wd;
    if (sz == 2'd0) return v;
    if (sz == 2'd1) return (v % 65536) * 32'h0001_0001;
    return (v % 256) * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input int a, input logic uns,
                                           input logic [31:0] rd);
    int unsigned v;
    if (sz == 2'd0) return rd;
    if (sz == 2'd1) begin
      v = (rd >> (16 * (a / 2))) % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = (rd >> (8 * a)) % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One core access; starts and ends in an IDLE cycle. rst_at >= 0 resets in that BUSY cycle.
  task automatic do_txn(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                        input int dly, input int rst_at,
                        output logic [31:0] o_rdata, output logic [3:0] o_be,
                        output logic [31:0] o_wdata, output logic [31:0] o_addr,
                        output int o_reqcyc, output logic o_err);
    int  a, nbusy;
    logic to;
    a = int'(addr % 4);
    o_rdata = 32'hDEAD_BEEF; o_be = 4'h0; o_wdata = 32'h0; o_addr = 32'h0;
    o_reqcyc = 0; o_err = 1'b0;
    core_req = 1'b1; core_write = wr; core_size = sz; core_unsigned = uns;
    core_addr = addr; core_wdata = wd; mem_ack_n = 1'($urandom_range(0, 1));
    exp_quiet(1'b1);
    @(negedge clk); o_reqcyc += int'(mem_req);
    if (misal(sz, a)) begin
      step();
      core_req = 1'b0; mem_ack_n = 1'b1;
      exp_quiet(1'b0); e_done = 1'b1; e_err = 1'b1;
      @(negedge clk);
      o_rdata = core_rdata; o_err = core_err; o_reqcyc += int'(mem_req);
      step();
      exp_quiet(1'b0);
      return;
    end
    nbusy = dly + 1;
    to = 1'b0;
`ifdef DBUS_TIMEOUT_EN
    if (nbusy > TMO) begin nbusy = TMO; to = 1'b1; end
`endif
    for (int i = 0; i < nbusy; i++) begin
      step();
      exp_quiet(1'b1);
      e_req = 1'b1; e_write = wr; e_addr = addr & 32'hFFFF_FFFC;
      e_be = ref_be(sz, a); e_wdata = wr ? ref_wdata(sz, wd) : 32'h0;
      mem_ack_n = (!to && i == dly) ? 1'b0 : 1'b1;
      mem_rdata = (i == dly) ? rd : $urandom;
      if (i == rst_at) rst = 1'b1;
      @(negedge clk);
      o_be = mem_be; o_wdata = mem_wdata; o_addr = mem_addr; o_reqcyc += int'(mem_req);
      if (i == rst_at) begin
        step();
        rst = 1'b0; core_req = 1'b0; mem_ack_n = 1'b1;
        exp_quiet(1'b0);
        return;
      end
    end
    step();
    core_req = 1'b0;
    mem_ack_n = to ? 1'b0 : 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    exp_quiet(1'b0); e_done = 1'b1; e_err = to;
    e_rdata = (to || wr) ? 32'h0 : ref_load(sz, a, uns, rd);
    @(negedge clk);
    o_rdata = core_rdata; o_err = core_err;
    step();
    mem_ack_n = 1'($urandom_range(0, 1));
    exp_quiet(1'b0);
  endtask

  logic [31:0] r_rdata, r_wdata, r_addr;
  logic [3:0]  r_be;
  int          r_req;
  logic        r_err;

  initial begin
    rst = 1'b1; core_req = 1'b0; core_write = 1'b0; core_size = 2'b00;
    core_unsigned = 1'b0; core_addr = 32'h0; core_wdata = 32'h0;
    mem_rdata = 32'h0; mem_ack_n = 1'b1;
    exp_quiet(1'b0);
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    step();

    // Byte load, signed, top lane.
    do_txn(1'b0, 2'd2, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, -1,
           r_rdata, r_be, r_wdata, r_addr, r_req, r_err);
    chk("lit_byte_rdata", r_rdata, 32'hFFFF_FF80);
    chk("lit_byte_be", {28'b0, r_be}, 32'h8);
    // Half store, upper lane.
    do_txn(1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 1, -1,
           r_rdata, r_be, r_wdata, r_addr, r_req, r_err);
    chk("lit_half_be", {28'b0, r_be}, 32'hC);
    chk("lit_half_wdata", r_wdata, 32'hABCD_ABCD);
    chk("lit_half_addr", r_addr, 32'h0000_0100);
    chk("lit_store_rdata", r_rdata, 32'h0);
    // Misaligned word load.
    do_txn(1'b0, 2'd0, 1'b0, 32'h0000_0101, 32'h0, 32'hFFFF_FFFF, 0, -1,
           r_rdata, r_be, r_wdata, r_addr, r_req, r_err);
    chk("lit_mis_err", {31'b0, r_err}, 32'h1);
    chk("lit_mis_rdata", r_rdata, 32'h0);
    chk("lit_mis_reqcyc", 32'(r_req), 32'd0);
    // Ack delayed 3 cycles; unsigned half load.
    do_txn(1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'h0, 32'h9876_5432, 3, -1,
           r_rdata, r_be, r_wdata, r_addr, r_req, r_err);
    chk("lit_dly_reqcyc", 32'(r_req), 32'd4);
    chk("lit_dly_rdata", r_rdata, 32'h0000_9876);
    // Reset in the middle of BUSY, then back-to-back accesses resume.
    do_txn(1'b1, 2'd0, 1'b0, 32'h0000_0040, 32'h1234_5678, 32'h0, 4, 2,
           r_rdata, r_be, r_wdata, r_addr, r_req, r_err);
    do_txn(1'b0, 2'd0, 1'b0, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, 0, -1,
           r_rdata, r_be, r_wdata, r_addr, r_req, r_err);
    chk("lit_after_rst_rdata", r_rdata, 32'hCAFE_F00D);
`ifdef DBUS_TIMEOUT_EN
    do_txn(1'b0, 2'd0, 1'b0, 32'h0000_0080, 32'h0, 32'h5555_5555, 40, -1,
           r_rdata, r_be, r_wdata, r_addr, r_req, r_err);
    chk("lit_tmo_reqcyc", 32'(r_req), 32'd16);
    chk("lit_tmo_err", {31'b0, r_err}, 32'h1);
    chk("lit_tmo_rdata", r_rdata, 32'h0);
`endif

    for (int n = 0; n < 300; n++) begin
      int dly, ra;
      dly = int'($urandom_range(0, 5));
      ra  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, dly)) : -1;
      do_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, $urandom, dly, ra,
             r_rdata, r_be, r_wdata, r_addr, r_req, r_err);
      if ($urandom_range(0, 3) == 0) begin
        mem_ack_n = 1'b0;
        step();
        mem_ack_n = 1'b1;
        exp_quiet(1'b0);
      end
    end

    step();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
